csr_arbiter: RTL and testbench

- Two-master arbiter that shares the single CSR bus (14-bit address, 32-bit data) between two requesters, e.g. the CPU bridge and a debug/DMA master.
- Drives the CSR slaves (sysctl, UART, etc.).
- Sequences each access: issue cycle, read-data wait, then a one-cycle acknowledge to the granted master.
- Uses round-robin fairness when both masters request at once.

---
 rtl/csr_arbiter.sv | 137 +++++++++++++
 tb/tb_csr_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/csr_arbiter.sv
// Two-master round-robin arbiter for the shared CSR bus.
// Each access runs IDLE -> ISSUE -> WAIT (read_wait cycles) -> ACK; all outputs are registered.
module csr_arbiter #(
    parameter int unsigned read_wait = 1  // legal range 1..15
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        m0_stb,
    input  logic [13:0] m0_a,
    input  logic        m0_we,
    input  logic [31:0] m0_di,
    output logic [31:0] m0_do,
    output logic        m0_ack,
    input  logic        m1_stb,
    input  logic [13:0] m1_a,
    input  logic        m1_we,
    input  logic [31:0] m1_di,
    output logic [31:0] m1_do,
    output logic        m1_ack,
    output logic [13:0] csr_a,
    output logic        csr_we,
    output logic [31:0] csr_di,
    input  logic [31:0] csr_do,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(read_wait - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        gnt_q, gnt_d;
    logic [13:0] csr_a_q, csr_a_d;
    logic        csr_we_q, csr_we_d;
    logic [31:0] csr_di_q, csr_di_d;
    logic [31:0] m0_do_q, m0_do_d, m1_do_q, m1_do_d;
    logic        m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
    logic        pick;

    // 1 selects master 1; on a tie the master not granted last time wins.
    assign pick = (m0_stb && m1_stb) ? ~last_q : m1_stb;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        csr_a_d  = csr_a_q;
        csr_we_d = 1'b0;
        csr_di_d = csr_di_q;
        m0_do_d  = m0_do_q;
        m1_do_d  = m1_do_q;
        m0_ack_d = 1'b0;
        m1_ack_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (m0_stb || m1_stb) begin
                    gnt_d    = pick;
                    last_d   = pick;
                    csr_a_d  = pick ? m1_a  : m0_a;
                    csr_di_d = pick ? m1_di : m0_di;
                    csr_we_d = pick ? m1_we : m0_we;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (gnt_q) begin
                        m1_do_d  = csr_do;
                        m1_ack_d = 1'b1;
                    end else begin
                        m0_do_d  = csr_do;
                        m0_ack_d = 1'b1;
                    end
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            csr_a_q  <= 14'd0;
            csr_we_q <= 1'b0;
            csr_di_q <= 32'd0;
            m0_do_q  <= 32'd0;
            m1_do_q  <= 32'd0;
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            csr_a_q  <= csr_a_d;
            csr_we_q <= csr_we_d;
            csr_di_q <= csr_di_d;
            m0_do_q  <= m0_do_d;
            m1_do_q  <= m1_do_d;
            m0_ack_q <= m0_ack_d;
            m1_ack_q <= m1_ack_d;
        end
    end

    assign csr_a       = csr_a_q;
    assign csr_we      = csr_we_q;
    assign csr_di      = csr_di_q;
    assign m0_do       = m0_do_q;
    assign m0_ack      = m0_ack_q;
    assign m1_do       = m1_do_q;
    assign m1_ack      = m1_ack_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_csr_arbiter.sv
// Directed bench for csr_arbiter: one DUT with read_wait=1 on a registered model slave,
// a second with read_wait=3 whose csr_do is driven cycle by cycle.
module tb_csr_arbiter;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    always #5 clk = ~clk;

    // DUT A, read_wait = 1
    logic        m0_stb = 1'b0, m0_we = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
    logic [13:0] m0_a = 14'd0, m1_a = 14'd0;
    logic [31:0] m0_di = 32'd0, m1_di = 32'd0;
    logic [31:0] m0_do, m1_do, csr_di, csr_do;
    logic        m0_ack, m1_ack, csr_we;
    logic [13:0] csr_a;
    logic [1:0]  dbg_a;

    // DUT B, read_wait = 3
    logic        b_m0_stb = 1'b0;
    logic [13:0] b_m0_a = 14'd0;
    logic [31:0] b_csr_do = 32'd0;
    logic [31:0] b_m0_do, b_m1_do, b_csr_di;
    logic        b_m0_ack, b_m1_ack, b_csr_we;
    logic [13:0] b_csr_a;
    logic [1:0]  dbg_b;

    int          errors = 0;
    int          checks = 0;
    int          we_cycles = 0;
    int          we_base;
    int          n;
    logic        which;
    logic [31:0] mem [16];

    csr_arbiter #(.read_wait(1)) dut_a (
        .sys_clk(clk), .sys_rst(sys_rst),
        .m0_stb(m0_stb), .m0_a(m0_a), .m0_we(m0_we), .m0_di(m0_di), .m0_do(m0_do), .m0_ack(m0_ack),
        .m1_stb(m1_stb), .m1_a(m1_a), .m1_we(m1_we), .m1_di(m1_di), .m1_do(m1_do), .m1_ack(m1_ack),
        .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di), .csr_do(csr_do), .dbg_state_o(dbg_a)
    );

    csr_arbiter #(.read_wait(3)) dut_b (
        .sys_clk(clk), .sys_rst(sys_rst),
        .m0_stb(b_m0_stb), .m0_a(b_m0_a), .m0_we(1'b0), .m0_di(32'd0), .m0_do(b_m0_do), .m0_ack(b_m0_ack),
        .m1_stb(1'b0), .m1_a(14'd0), .m1_we(1'b0), .m1_di(32'd0), .m1_do(b_m1_do), .m1_ack(b_m1_ack),
        .csr_a(b_csr_a), .csr_we(b_csr_we), .csr_di(b_csr_di), .csr_do(b_csr_do), .dbg_state_o(dbg_b)
    );

    // Registered slave: writes store and echo csr_di, reads return mem one cycle later.
    always @(posedge clk) begin
        if (sys_rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'(i);
            mem[5]  <= 32'hDEADBEEF;
            mem[7]  <= 32'hCAFEF00D;
            mem[8]  <= 32'h01234567;
            csr_do  <= 32'd0;
        end else if (csr_we) begin
            mem[csr_a[3:0]] <= csr_di;
            csr_do          <= csr_di;
        end else begin
            csr_do <= mem[csr_a[3:0]];
        end
    end

    always @(negedge clk) if (csr_we === 1'b1) we_cycles++;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Ticks until either ack of DUT A is seen (bounded); returns ticks taken and which master.
    task automatic wait_any(output logic who, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!m0_ack && !m1_ack && cnt < 20);
        who = m1_ack;
        check("ack_exclusive", 32'(m0_ack & m1_ack), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_csr_a"},  32'(csr_a),  32'd0);
        check({tag, "_csr_we"}, 32'(csr_we), 32'd0);
        check({tag, "_csr_di"}, csr_di,      32'd0);
        check({tag, "_m0_do"},  m0_do,       32'd0);
        check({tag, "_m1_do"},  m1_do,       32'd0);
        check({tag, "_m0_ack"}, 32'(m0_ack), 32'd0);
        check({tag, "_m1_ack"}, 32'(m1_ack), 32'd0);
    endtask

    initial begin
        // reset
        repeat (2) tick();
        check_reset_outputs("rst");
        sys_rst = 1'b0;
        tick();

        // single read by m0 from 0x0005
        we_base = we_cycles;
        m0_stb = 1'b1; m0_a = 14'h0005; m0_we = 1'b0;
        wait_any(which, n);
        check("rd_latency", 32'(n), 32'd3);
        check("rd_who", 32'(which), 32'd0);
        check("rd_m0_do", m0_do, 32'hDEADBEEF);
        check("rd_m1_ack", 32'(m1_ack), 32'd0);
        tick();
        check("rd_ack_pulse", 32'(m0_ack), 32'd0);
        m0_stb = 1'b0;
        check("rd_no_we", 32'(we_cycles - we_base), 32'd0);
        tick();

        // single write by m1 of 0x12345678 to 0x0006
        we_base = we_cycles;
        m1_stb = 1'b1; m1_a = 14'h0006; m1_we = 1'b1; m1_di = 32'h12345678;
        tick();
        check("wr_issue_we", 32'(csr_we), 32'd1);
        check("wr_issue_a", 32'(csr_a), 32'h0006);
        check("wr_issue_di", csr_di, 32'h12345678);
        tick();
        check("wr_we_drop", 32'(csr_we), 32'd0);
        check("wr_a_hold", 32'(csr_a), 32'h0006);
        tick();
        check("wr_m1_ack", 32'(m1_ack), 32'd1);
        check("wr_m1_do", m1_do, 32'h12345678);
        check("wr_m0_ack", 32'(m0_ack), 32'd0);
        check("wr_m0_do", m0_do, 32'hDEADBEEF);
        tick();
        check("wr_ack_pulse", 32'(m1_ack), 32'd0);
        m1_stb = 1'b0; m1_we = 1'b0;
        check("wr_one_we", 32'(we_cycles - we_base), 32'd1);

        // simultaneous requests right after reset: m0 first, then m1
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        tick();
        m0_stb = 1'b1; m0_a = 14'h0007;
        m1_stb = 1'b1; m1_a = 14'h0008;
        wait_any(which, n);
        check("sim_first_lat", 32'(n), 32'd3);
        check("sim_first_who", 32'(which), 32'd0);
        check("sim_m0_do", m0_do, 32'hCAFEF00D);
        tick();
        m0_stb = 1'b0;
        wait_any(which, n);
        check("sim_second_gap", 32'(n), 32'd3);
        check("sim_second_who", 32'(which), 32'd1);
        check("sim_m1_do", m1_do, 32'h01234567);
        check("sim_m0_do_kept", m0_do, 32'hCAFEF00D);
        tick();
        m1_stb = 1'b0;
        tick();

        // continuous contention: six grants alternating m0, m1, ...
        we_base = we_cycles;
        m0_stb = 1'b1; m0_a = 14'h0005;
        m1_stb = 1'b1; m1_a = 14'h0008;
        for (int i = 0; i < 6; i++) begin
            wait_any(which, n);
            check("cont_who", 32'(which), 32'(i % 2));
            check("cont_gap", 32'(n), (i == 0) ? 32'd3 : 32'd4);
            if (which) check("cont_m1_do", m1_do, 32'h01234567);
            else       check("cont_m0_do", m0_do, 32'hDEADBEEF);
        end
        tick();
        m0_stb = 1'b0; m1_stb = 1'b0;
        check("cont_no_we", 32'(we_cycles - we_base), 32'd0);
        tick();

        // read_wait = 3: data present only on the third cycle after issue
        b_m0_stb = 1'b1; b_m0_a = 14'h000A;
        n = 0;
        do begin
            tick();
            n++;
            b_csr_do = (n == 4) ? 32'hA5A5A5A5 : 32'd0;
        end while (!b_m0_ack && n < 20);
        check("rw3_latency", 32'(n), 32'd5);
        check("rw3_m0_do", b_m0_do, 32'hA5A5A5A5);
        check("rw3_m1_ack", 32'(b_m1_ack), 32'd0);
        tick();
        b_m0_stb = 1'b0;
        check("rw3_ack_pulse", 32'(b_m0_ack), 32'd0);

        // reset while in WAIT: pending ack cancelled, tie goes back to m0
        m0_stb = 1'b1; m0_a = 14'h0005;
        tick();
        tick();
        sys_rst = 1'b1;
        tick();
        check_reset_outputs("rstw");
        sys_rst = 1'b0;
        m0_stb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rstw_no_ack", 32'(m0_ack | m1_ack), 32'd0);
        end
        m0_stb = 1'b1; m0_a = 14'h0007;
        m1_stb = 1'b1; m1_a = 14'h0008;
        wait_any(which, n);
        check("rstw_tie_who", 32'(which), 32'd0);
        check("rstw_tie_lat", 32'(n), 32'd3);
        check("rstw_m0_do", m0_do, 32'hCAFEF00D);
        tick();
        m0_stb = 1'b0; m1_stb = 1'b0;
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
